keypad_digit_buffer: RTL and testbench
======================================

# keypad_digit_buffer

Parametrised digit-entry buffer between the keypad scanner and the display/compute logic. Turns keypad strobes into digit-shift, backspace, clear and enter operations, and keeps a count of held digits. Generalises the single-direction 8-digit key shifter: configurable digit count, digit width and entry direction. Adds an in-clock-domain strobe synchroniser, overflow/drop flags and a valid/ready commit port.

## Interface
- DIGITS, 8: digit slots held; legal range 2..16.
- DIGIT_W, 4: bits per digit.
- SYNC_STAGES, 2: synchroniser depth for KeyPressFlag; legal range 2..4.
- LEFT_ENTRY, 1: 1 = newest digit enters at the MS slot, shifting right; 0 = newest digit enters at the LS slot, shifting left (calculator style).
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- en  in  1  key-event enable; when 0, key events are discarded.
- KeyPressFlag  in  1  asynchronous strobe from the scanner; each rising edge is one key event.
- InputData  in  DIGIT_W  digit value; held stable by the scanner from the KeyPressFlag rise until the event is taken.
- KeyCmd  in  2  00 digit, 01 backspace, 10 clear, 11 enter; same stability rule as InputData.
- OutputData  out  DIGITS*DIGIT_W  live digit buffer.
- CntNum  out  CNT_W=$clog2(DIGITS+1)  number of digits held, 0..DIGITS.
- Full  out  1  CntNum==DIGITS.
- Overflow  out  1  one-cycle pulse: a digit was entered while Full, discarding the oldest digit.
- Drop  out  1  one-cycle pulse: enter was rejected because a commit is pending.
- CommitData  out  DIGITS*DIGIT_W  buffer snapshot taken at enter.
- CommitCount  out  CNT_W  CntNum snapshot taken at enter.
- CommitValid  out  1  commit pending.
- CommitReady  in  1  consumer accepts the commit.

## Operation
- Synchroniser: sync chain s[0..SYNC_STAGES-1], then prev <= s_last.
  - armed is cleared by RST and set once s_last==0 is seen.
  - event = s_last & ~prev & armed. A strobe held high through reset release produces no event.
- en=0: event is ignored. The chain, prev and armed keep running, so no stale event appears when en returns to 1. The commit handshake runs regardless of en.
- Digit (LEFT_ENTRY=1): buffer <= {InputData, buffer[top:DIGIT_W]}.
- Digit (LEFT_ENTRY=0): buffer <= {buffer[top-DIGIT_W:0], InputData}.
  - If not Full: CntNum+1.
  - If Full: the oldest digit falls off the far end, CntNum is unchanged and Overflow pulses.
- Backspace removes the newest digit. Zero fill comes in from the newest-digit end's opposite side, i.e. the reverse shift of digit entry. CntNum-1. No effect when CntNum==0.
- Clear: buffer and CntNum go to 0. A pending commit is unaffected.
- Enter with CommitValid=0, or with CommitValid & CommitReady in the same cycle:
  - CommitData <= buffer, CommitCount <= CntNum, CommitValid <= 1.
  - Buffer and CntNum are cleared.
  - Enter with CntNum==0 still commits, with count 0.
- Enter with CommitValid=1 and CommitReady=0: Drop pulses; buffer, count and the commit registers are unchanged.
- Handshake: a transfer occurs when CommitValid & CommitReady. CommitValid falls at the next edge unless a simultaneous enter reloads it. CommitData and CommitCount are stable while CommitValid=1.

## Timing
- RST: every output and internal register is 0 (OutputData, CntNum, Full, Overflow, Drop, CommitData, CommitCount, CommitValid, chain, prev, armed).
- RST mid-operation overrides any event or handshake in that cycle and discards a pending commit.
- Key latency: the first CLK edge sampling KeyPressFlag=1 is edge k. The event is acted on at edge k+SYNC_STAGES, and OutputData, CntNum and flags are visible after that edge. InputData and KeyCmd are sampled at that same edge.
- Minimum event spacing: KeyPressFlag low for at least SYNC_STAGES+1 cycles between strobes. Shorter gaps may merge strobes.
- Overflow and Drop are high for exactly the cycle after the acting edge.
- Full is registered and tracks CntNum in the same cycle.
- Handshake costs zero bubbles: back-to-back commits are possible every cycle.

## Test plan
- Reset, then digits 1,2,3 (defaults) -> OutputData 0x1000_0000, 0x2100_0000, 0x3210_0000; CntNum 1,2,3; each update exactly SYNC_STAGES edges after the strobe is first sampled.
- Digits 1..9 -> Full=1 after the 8th digit; 9th gives a one-cycle Overflow pulse, OutputData 0x9876_5432, CntNum 8.
- Digits 1,2,3, backspace -> 0x2100_0000, CntNum 2; clear, then backspace -> 0x0, CntNum 0, no flags.
- Digits 1,2, enter, CommitReady=0 -> CommitValid=1, CommitData 0x2100_0000, CommitCount 2, buffer 0. Second enter -> Drop pulse, commit unchanged. CommitReady high for 1 cycle -> CommitValid 0 at the next edge. Enter coincident with Ready -> CommitValid stays 1 with the new data.
- LEFT_ENTRY=0, DIGITS=4: digits 1,2,3 -> 0x0123; backspace -> 0x0012; digits 4,5,6 -> 0x2456 with an Overflow pulse on 6.
- Strobe with en=0 -> no change. KeyPressFlag held high across RST deassert -> no event. RST while CommitValid=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/keypad_digit_buffer.sv
// Digit-entry buffer: synchronises keypad strobes and applies digit/backspace/clear/enter
// to a DIGITS-wide shift buffer, with a valid/ready commit port for entered values.
module keypad_digit_buffer #(
  parameter int DIGITS      = 8,
  parameter int DIGIT_W     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEFT_ENTRY  = 1,
  localparam int CNT_W      = $clog2(DIGITS + 1),
  localparam int BUF_W      = DIGITS * DIGIT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               KeyPressFlag,
  input  logic [DIGIT_W-1:0] InputData,
  input  logic [1:0]         KeyCmd,
  output logic [BUF_W-1:0]   OutputData,
  output logic [CNT_W-1:0]   CntNum,
  output logic               Full,
  output logic               Overflow,
  output logic               Drop,
  output logic [BUF_W-1:0]   CommitData,
  output logic [CNT_W-1:0]   CommitCount,
  output logic               CommitValid,
  input  logic               CommitReady
);

  typedef enum logic [1:0] {
    CMD_DIGIT = 2'b00,
    CMD_BKSP  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_ENTER = 2'b11
  } cmd_e;

  logic [SYNC_STAGES-1:0] sync_q, vld_pipe_q;
  logic                   prev_q, armed_q, s_last, key_evt;
  logic [BUF_W-1:0]       buf_q, buf_d, cd_q, cd_d, dig_shift, bs_shift;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cc_q, cc_d;
  logic                   full_q, full_d, ovf_q, ovf_d, drop_q, drop_d, cv_q, cv_d;

  assign s_last  = sync_q[SYNC_STAGES-1];
  assign key_evt = s_last & ~prev_q & armed_q;

  // Newest digit enters at one end; backspace is the reverse shift with zero fill.
  generate
    if (LEFT_ENTRY != 0) begin : g_left
      assign dig_shift = {InputData, buf_q[BUF_W-1:DIGIT_W]};
      assign bs_shift  = {buf_q[BUF_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
    end else begin : g_right
      assign dig_shift = {buf_q[BUF_W-DIGIT_W-1:0], InputData};
      assign bs_shift  = {{DIGIT_W{1'b0}}, buf_q[BUF_W-1:DIGIT_W]};
    end
  endgenerate

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    drop_d = 1'b0;
    cv_d   = cv_q & ~CommitReady;
    cd_d   = cd_q;
    cc_d   = cc_q;
    if (key_evt && en) begin
      case (cmd_e'(KeyCmd))
        CMD_DIGIT: begin
          buf_d = dig_shift;
          if (full_q) ovf_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        CMD_BKSP: begin
          if (cnt_q != '0) begin
            buf_d = bs_shift;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        CMD_CLEAR: begin
          buf_d = '0;
          cnt_d = '0;
        end
        default: begin
          // A commit slot frees up in the same cycle it is accepted.
          if (!cv_q || CommitReady) begin
            cd_d  = buf_q;
            cc_d  = cnt_q;
            cv_d  = 1'b1;
            buf_d = '0;
            cnt_d = '0;
          end else begin
            drop_d = 1'b1;
          end
        end
      endcase
    end
    full_d = (cnt_d == CNT_W'(DIGITS));
  end

  // vld_pipe_q marks chain stages holding post-reset samples, so arming needs a real low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      buf_q      <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      cv_q       <= 1'b0;
      cd_q       <= '0;
      cc_q       <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], KeyPressFlag};
      vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= s_last;
      armed_q    <= armed_q | (vld_pipe_q[SYNC_STAGES-1] & ~s_last);
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      cv_q       <= cv_d;
      cd_q       <= cd_d;
      cc_q       <= cc_d;
    end
  end

  assign OutputData  = buf_q;
  assign CntNum      = cnt_q;
  assign Full        = full_q;
  assign Overflow    = ovf_q;
  assign Drop        = drop_q;
  assign CommitData  = cd_q;
  assign CommitCount = cc_q;
  assign CommitValid = cv_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Scoreboard bench: stimulus queues hand-computed expected states tagged with a cycle,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_keypad_digit_buffer;

  typedef struct {
    int          cyc;
    logic [31:0] od;
    int          cnt;
    bit          full, ovf, drop, cv;
    logic [31:0] cd;
    int          cc;
  } exp_t;

  localparam logic [1:0] K_DIG = 2'b00, K_BS = 2'b01, K_CLR = 2'b10, K_ENT = 2'b11;

  logic        clk = 1'b0;
  logic        rst, en, kpf_a, kpf_b, rdy;
  logic [3:0]  din;
  logic [1:0]  cmd;
  logic [31:0] od_a, cd_a;
  logic [3:0]  cnt_a, cc_a;
  logic        full_a, ovf_a, drop_a, cv_a;
  logic [15:0] od_b, cd_b;
  logic [2:0]  cnt_b, cc_b;
  logic        full_b, ovf_b, drop_b, cv_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b, ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_digit_buffer u_a (
    .CLK(clk), .RST(rst), .en(en), .KeyPressFlag(kpf_a), .InputData(din), .KeyCmd(cmd),
    .OutputData(od_a), .CntNum(cnt_a), .Full(full_a), .Overflow(ovf_a), .Drop(drop_a),
    .CommitData(cd_a), .CommitCount(cc_a), .CommitValid(cv_a), .CommitReady(rdy)
  );

  keypad_digit_buffer #(.DIGITS(4), .LEFT_ENTRY(0)) u_b (
    .CLK(clk), .RST(rst), .en(en), .KeyPressFlag(kpf_b), .InputData(din), .KeyCmd(cmd),
    .OutputData(od_b), .CntNum(cnt_b), .Full(full_b), .Overflow(ovf_b), .Drop(drop_b),
    .CommitData(cd_b), .CommitCount(cc_b), .CommitValid(cv_b), .CommitReady(1'b0)
  );

  function automatic exp_t mk(logic [31:0] od, int cnt, bit full, bit ovf = 0, bit drop = 0,
                              bit cv = 0, logic [31:0] cd = 0, int cc = 0);
    exp_t e;
    e.cyc = 0; e.od = od; e.cnt = cnt; e.full = full; e.ovf = ovf; e.drop = drop;
    e.cv = cv; e.cd = cd; e.cc = cc;
    return e;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d got %h want %h", nm, inst, cyc, got, want);
    end
  endtask

  task automatic cmp(input int inst, input exp_t e, input logic [31:0] od, input logic [31:0] cnt,
                     input logic fl, input logic ov, input logic dr, input logic cv,
                     input logic [31:0] cd, input logic [31:0] cc);
    chk("OutputData", inst, od, e.od);
    chk("CntNum", inst, cnt, 32'(e.cnt));
    chk("Full", inst, {31'b0, fl}, {31'b0, e.full});
    chk("Overflow", inst, {31'b0, ov}, {31'b0, e.ovf});
    chk("Drop", inst, {31'b0, dr}, {31'b0, e.drop});
    chk("CommitValid", inst, {31'b0, cv}, {31'b0, e.cv});
    if (e.cv) begin
      chk("CommitData", inst, cd, e.cd);
      chk("CommitCount", inst, cc, 32'(e.cc));
    end
  endtask

  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      ea = qa.pop_front();
      if (ea.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL late_check inst0 got cyc%0d want cyc%0d", cyc, ea.cyc);
      end else
        cmp(0, ea, od_a, {28'b0, cnt_a}, full_a, ovf_a, drop_a, cv_a, cd_a, {28'b0, cc_a});
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      eb = qb.pop_front();
      if (eb.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL late_check inst1 got cyc%0d want cyc%0d", cyc, eb.cyc);
      end else
        cmp(1, eb, {16'b0, od_b}, {29'b0, cnt_b}, full_b, ovf_b, drop_b, cv_b, {16'b0, cd_b}, {29'b0, cc_b});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int inst, input exp_t e, input int at);
    exp_t t;
    t = e;
    t.cyc = at;
    if (inst == 0) qa.push_back(t);
    else           qb.push_back(t);
  endtask

  // Strobe one key; expect old state one edge before the acting edge, e after it,
  // and the flags cleared one edge later.
  task automatic key(input int inst, input logic [1:0] c, input logic [3:0] d, input exp_t e,
                     input bit rdy_act = 0);
    int   c0;
    exp_t pre, post;
    c0   = cyc;
    pre  = (inst == 0) ? cur_a : cur_b;
    post = e;
    post.ovf = 0;
    post.drop = 0;
    push(inst, pre, c0 + 2);
    push(inst, e, c0 + 3);
    push(inst, post, c0 + 4);
    if (inst == 0) cur_a = post;
    else           cur_b = post;
    cmd = c;
    din = d;
    if (inst == 0) kpf_a = 1'b1;
    else           kpf_b = 1'b1;
    tick(1);
    kpf_a = 1'b0;
    kpf_b = 1'b0;
    tick(1);
    if (rdy_act) rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    tick(3);
  endtask

  task automatic zero_checks(input int n);
    repeat (n) begin
      push(0, cur_a, cyc);
      push(1, cur_b, cyc);
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc%0d got timeout want finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; kpf_a = 1'b0; kpf_b = 1'b0; rdy = 1'b0; din = '0; cmd = '0;
    cur_a = mk(0, 0, 0);
    cur_b = mk(0, 0, 0);
    tick(2);
    zero_checks(1);
    rst = 1'b0;
    tick(4);

    // Left entry, digits 1..9: fill, Full, then overflow
    key(0, K_DIG, 1, mk(32'h1000_0000, 1, 0));
    key(0, K_DIG, 2, mk(32'h2100_0000, 2, 0));
    key(0, K_DIG, 3, mk(32'h3210_0000, 3, 0));
    key(0, K_DIG, 4, mk(32'h4321_0000, 4, 0));
    key(0, K_DIG, 5, mk(32'h5432_1000, 5, 0));
    key(0, K_DIG, 6, mk(32'h6543_2100, 6, 0));
    key(0, K_DIG, 7, mk(32'h7654_3210, 7, 0));
    key(0, K_DIG, 8, mk(32'h8765_4321, 8, 1));
    key(0, K_DIG, 9, mk(32'h9876_5432, 8, 1, 1));

    // Clear, backspace, backspace on empty
    key(0, K_CLR, 0, mk(0, 0, 0));
    key(0, K_DIG, 1, mk(32'h1000_0000, 1, 0));
    key(0, K_DIG, 2, mk(32'h2100_0000, 2, 0));
    key(0, K_DIG, 3, mk(32'h3210_0000, 3, 0));
    key(0, K_BS,  0, mk(32'h2100_0000, 2, 0));
    key(0, K_CLR, 0, mk(0, 0, 0));
    key(0, K_BS,  0, mk(0, 0, 0));

    // Commit, drop on second enter, handshake, enter coincident with ready
    key(0, K_DIG, 1, mk(32'h1000_0000, 1, 0));
    key(0, K_DIG, 2, mk(32'h2100_0000, 2, 0));
    key(0, K_ENT, 0, mk(0, 0, 0, 0, 0, 1, 32'h2100_0000, 2));
    key(0, K_ENT, 0, mk(0, 0, 0, 0, 1, 1, 32'h2100_0000, 2));
    push(0, cur_a, cyc);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    cur_a = mk(0, 0, 0);
    push(0, cur_a, cyc);
    tick(2);
    key(0, K_DIG, 5, mk(32'h5000_0000, 1, 0));
    key(0, K_ENT, 0, mk(0, 0, 0, 0, 0, 1, 32'h5000_0000, 1));
    key(0, K_DIG, 7, mk(32'h7000_0000, 1, 0, 0, 0, 1, 32'h5000_0000, 1));
    key(0, K_ENT, 0, mk(0, 0, 0, 0, 0, 1, 32'h7000_0000, 1), 1);

    // Reset with a pending commit
    push(0, cur_a, cyc);
    rst = 1'b1;
    tick(1);
    cur_a = mk(0, 0, 0);
    push(0, cur_a, cyc);
    rst = 1'b0;
    tick(4);

    // Strobe held high through reset release gives no event
    kpf_a = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    zero_checks(6);
    kpf_a = 1'b0;
    zero_checks(6);
    key(0, K_DIG, 4, mk(32'h4000_0000, 1, 0));

    // en=0 discards the event, and no stale event follows
    en = 1'b0;
    key(0, K_DIG, 3, cur_a);
    en = 1'b1;
    zero_checks(3);
    key(0, K_DIG, 6, mk(32'h6400_0000, 2, 0));

    // Right entry, 4 digits
    key(1, K_DIG, 1, mk(32'h0001, 1, 0));
    key(1, K_DIG, 2, mk(32'h0012, 2, 0));
    key(1, K_DIG, 3, mk(32'h0123, 3, 0));
    key(1, K_BS,  0, mk(32'h0012, 2, 0));
    key(1, K_DIG, 4, mk(32'h0124, 3, 0));
    key(1, K_DIG, 5, mk(32'h1245, 4, 1));
    key(1, K_DIG, 6, mk(32'h2456, 4, 1, 1));

    tick(3);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_checks got %0d want 0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
